// File: rtl/pc_seq.sv
// Program-counter sequencer for the fetch stage: increment, stall, jump,
// PC-relative branch, and call/return through a small return-address stack.
module pc_seq #(
  parameter int unsigned               ADDR_W      = 8,
  parameter int unsigned               STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0]         RESET_ADDR  = '0,
  localparam int unsigned              CNT_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_off,
  input  logic              call_en,
  input  logic              ret_en,
  output logic [ADDR_W-1:0] pc_out,
  output logic [CNT_W-1:0]  stack_cnt,
  output logic              stack_ovf,
  output logic              stack_unf
);

  localparam int unsigned PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] top;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              ovf_nxt;
  logic              unf_nxt;
  logic              push;
  logic              full;
  logic              empty;
  logic [PTR_W-1:0]  wr_idx;
  logic [PTR_W-1:0]  rd_idx;

  assign pc_inc = pc_out + ADDR_W'(1);
  assign full   = (stack_cnt == CNT_W'(STACK_DEPTH));
  assign empty  = (stack_cnt == '0);
  // Pointer is the entry count: write at cnt, read the top at cnt-1.
  assign wr_idx = PTR_W'(stack_cnt);
  assign rd_idx = empty ? '0 : PTR_W'(stack_cnt - CNT_W'(1));
  assign top    = stack_mem[rd_idx];

  // Next-state selection in priority order: stall, ret, call, jump, branch, inc.
  always_comb begin
    pc_nxt  = pc_out;
    cnt_nxt = stack_cnt;
    ovf_nxt = stack_ovf;
    unf_nxt = stack_unf;
    push    = 1'b0;
    if (!stall) begin
      if (ret_en) begin
        if (!empty) begin
          pc_nxt  = top;
          cnt_nxt = stack_cnt - CNT_W'(1);
        end else begin
          pc_nxt  = pc_inc;
          unf_nxt = 1'b1;
        end
      end else if (call_en) begin
        pc_nxt = jump_addr;
        if (!full) begin
          push    = 1'b1;
          cnt_nxt = stack_cnt + CNT_W'(1);
        end else begin
          ovf_nxt = 1'b1;
        end
      end else if (jump_en) begin
        pc_nxt = jump_addr;
      end else if (branch_en) begin
        pc_nxt = pc_out + branch_off;
      end else begin
        pc_nxt = pc_inc;
      end
    end
  end

  // Architectural state; reset empties the stack by clearing the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_out    <= RESET_ADDR;
      stack_cnt <= '0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else begin
      pc_out    <= pc_nxt;
      stack_cnt <= cnt_nxt;
      stack_ovf <= ovf_nxt;
      stack_unf <= unf_nxt;
    end
  end

  // Stack storage carries no reset; entries at or above the count are don't-care.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_mem[wr_idx] <= pc_inc;
    end
  end

endmodule
